// File: rtl/fp_adder_pkg.sv
// Shared constants and types for the half-precision adder datapath
// (leading-one detector, post-normalization, packing).
package fp_adder_pkg;

    localparam int SUM_W   = 12;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;
    localparam int E_W     = 7;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Working exponent: wide enough for exp+2 on top and exp-10 underneath.
    typedef logic signed [E_W-1:0] exp_s_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp16_t;

endpackage

// File: rtl/norm_shifter.sv
// Combinational normalize shift, round-half-up-to-even on the single guard bit,
// and renormalization when the rounding increment carries into bit 11.
module norm_shifter
    import fp_adder_pkg::*;
(
    input  logic [SUM_W-1:0] m_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic             dir_i,
    input  logic [3:0]       n_i,
    output logic [MAN_W-1:0] s_o,
    output exp_s_t           e_o,
    output logic             zero_o
);

    logic [SUM_W-1:0] sh;
    logic [3:0]       n;
    logic             g;
    exp_s_t           ev;

    always_comb begin
        // Out-of-range left shifts are clamped to the widest legal shift.
        n  = (n_i > 4'd10) ? 4'd10 : n_i;
        sh = '0;
        g  = 1'b0;
        ev = '0;
        if (dir_i == DIR_RIGHT) begin
            sh = m_i >> 1;
            g  = m_i[0];
            ev = $signed({2'b00, exp_i}) + 7'sd1;
        end else begin
            sh = m_i << n;
            g  = 1'b0;
            ev = $signed({2'b00, exp_i}) - $signed({3'b000, n});
        end
        if (g & sh[0]) begin
            sh = sh + 12'd1;
            if (sh[SUM_W-1]) begin
                sh = sh >> 1;
                ev = ev + 7'sd1;
            end
        end
    end

    assign s_o    = sh[MAN_W-1:0];
    assign e_o    = ev;
    assign zero_o = (m_i == '0);

endmodule

// File: rtl/norm_round_pack.sv
// Two-stage post-normalization: stage 1 shifts/rounds, stage 2 classifies
// (zero / overflow / flush) and packs binary16, with sticky ovf/unf flags.
module norm_round_pack
    import fp_adder_pkg::*;
(
    input  logic             clk73,
    input  logic             rst_n73,
    input  logic             in_valid73,
    output logic             in_ready73,
    input  logic [SUM_W-1:0] m_sum73,
    input  logic [EXP_W-1:0] exp73,
    input  logic             sign73,
    input  logic             dir73,
    input  logic [3:0]       N73,
    output logic             out_valid73,
    input  logic             out_ready73,
    output logic [15:0]      result73,
    output logic             ovf73,
    output logic             unf73,
    input  logic             clr_flags73
);

    logic [MAN_W-1:0] sh_s;
    exp_s_t           sh_e;
    logic             sh_zero;

    logic             s1_valid_q, s1_valid_d;
    logic [MAN_W-1:0] s1_frac_q;
    exp_s_t           s1_e_q;
    logic             s1_zero_q, s1_sign_q;

    logic             s2_valid_q, s2_valid_d;
    fp16_t            res_q, pk;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             set_ovf, set_unf;
    logic             in_acc, s2_adv;

    norm_shifter u_shift (
        .m_i    (m_sum73),
        .exp_i  (exp73),
        .dir_i  (dir73),
        .n_i    (N73),
        .s_o    (sh_s),
        .e_o    (sh_e),
        .zero_o (sh_zero)
    );

    // Each stage may refill in the same cycle its contents move on.
    assign in_ready73 = !s1_valid_q | !s2_valid_q | out_ready73;
    assign in_acc     = in_valid73 & in_ready73;
    assign s2_adv     = s1_valid_q & (!s2_valid_q | out_ready73);
    assign s1_valid_d = in_acc | (s1_valid_q & !s2_adv);
    assign s2_valid_d = s2_adv | (s2_valid_q & !out_ready73);

    always_comb begin
        pk      = '0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (s1_zero_q) begin
            pk = '0;
        end else if (s1_e_q >= 7'sd31) begin
            pk.sign = s1_sign_q;
            pk.exp  = EXP_W'(EXP_MAX);
            set_ovf = 1'b1;
        end else if (s1_e_q <= 7'sd0) begin
            pk.sign = s1_sign_q;
            set_unf = 1'b1;
        end else begin
            pk.sign = s1_sign_q;
            pk.exp  = s1_e_q[EXP_W-1:0];
            pk.frac = s1_frac_q;
        end
    end

    // A set in the same cycle as a clear takes priority.
    assign ovf_d = (ovf_q & !clr_flags73) | (s2_adv & set_ovf);
    assign unf_d = (unf_q & !clr_flags73) | (s2_adv & set_unf);

    always_ff @(posedge clk73 or negedge rst_n73) begin
        if (!rst_n73) begin
            s1_valid_q <= 1'b0;
            s1_frac_q  <= '0;
            s1_e_q     <= '0;
            s1_zero_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_acc) begin
                s1_frac_q <= sh_s;
                s1_e_q    <= sh_e;
                s1_zero_q <= sh_zero;
                s1_sign_q <= sign73;
            end
            s2_valid_q <= s2_valid_d;
            if (s2_adv) res_q <= pk;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out_valid73 = s2_valid_q;
    assign result73    = res_q;
    assign ovf73       = ovf_q;
    assign unf73       = unf_q;

endmodule

// File: tb/tb_norm_round_pack.sv
// Bench for norm_round_pack: directed vector table, stall/reset/flag sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_norm_round_pack;
    import fp_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sign, dir, out_valid, out_ready;
    logic        ovf, unf, clr;
    logic [11:0] m;
    logic [4:0]  ex;
    logic [3:0]  n;
    logic [15:0] result;

    int vectors = 0, miscompares = 0, popped = 0;
    logic mdl_ovf = 1'b0, mdl_unf = 1'b0;

    always #5 clk = ~clk;

    norm_round_pack dut (
        .clk73(clk), .rst_n73(rst_n), .in_valid73(in_valid), .in_ready73(in_ready),
        .m_sum73(m), .exp73(ex), .sign73(sign), .dir73(dir), .N73(n),
        .out_valid73(out_valid), .out_ready73(out_ready), .result73(result),
        .ovf73(ovf), .unf73(unf), .clr_flags73(clr)
    );

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        unf;
    } ref_t;

    typedef struct {
        logic [11:0] m;
        logic [4:0]  e;
        logic        s;
        logic        d;
        logic [3:0]  n;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    ref_t expq[$];

    // Reference: treat the sum as an integer and follow the rounding rules arithmetically.
    function automatic ref_t ref_model(logic [11:0] mm, logic [4:0] ee, logic ss, logic dd, logic [3:0] nn);
        ref_t r;
        int sh, sv, ev, g;
        r.res = 16'h0000; r.ovf = 1'b0; r.unf = 1'b0;
        if (mm == 0) return r;
        sh = (int'(nn) > 10) ? 10 : int'(nn);
        if (dd) begin
            sv = int'(mm) / 2; g = int'(mm) % 2; ev = int'(ee) + 1;
        end else begin
            sv = (int'(mm) * (1 << sh)) % 4096; g = 0; ev = int'(ee) - sh;
        end
        if (g == 1 && (sv % 2) == 1) begin
            sv = sv + 1;
            if (sv >= 2048) begin sv = sv / 2; ev = ev + 1; end
        end
        if (ev >= 31) begin
            r.res = {ss, 15'h7C00}; r.ovf = 1'b1;
        end else if (ev <= 0) begin
            r.res = {ss, 15'h0000}; r.unf = 1'b1;
        end else begin
            r.res = {ss, 5'(ev), 10'(sv % 1024)};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        ref_t r;
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) check("unexpected output", 32'd1, 32'd0);
                else begin
                    r = expq.pop_front();
                    check("stream result", 32'(result), 32'(r.res));
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                r = ref_model(m, ex, sign, dir, n);
                expq.push_back(r);
                if (r.ovf) mdl_ovf = 1'b1;
                if (r.unf) mdl_unf = 1'b1;
            end
        end
    end

    task automatic set_in(input logic [11:0] mm, input logic [4:0] ee, input logic ss, input logic dd, input logic [3:0] nn);
        m = mm; ex = ee; sign = ss; dir = dd; n = nn;
    endtask

    // Call just after a posedge; returns just after the accepting posedge.
    task automatic drive(input logic [11:0] mm, input logic [4:0] ee, input logic ss, input logic dd, input logic [3:0] nn);
        int t = 0;
        set_in(mm, ee, ss, dd, nn);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin t++; @(negedge clk); end
        if (!in_ready) check("drive timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        mdl_ovf = 1'b0; mdl_unf = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (expq.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
        check(name, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[14];

    initial begin
        logic [15:0] held;
        int base;
        logic done;

        tbl[0]  = '{12'h400, 5'd15, 1'b0, 1'b0, 4'd0,  16'h3C00, 1'b0, 1'b0};
        tbl[1]  = '{12'h803, 5'd15, 1'b0, 1'b1, 4'd0,  16'h4002, 1'b0, 1'b0};
        tbl[2]  = '{12'hFFF, 5'd15, 1'b0, 1'b1, 4'd0,  16'h4400, 1'b0, 1'b0};
        tbl[3]  = '{12'h001, 5'd20, 1'b0, 1'b0, 4'd10, 16'h2800, 1'b0, 1'b0};
        tbl[4]  = '{12'h001, 5'd5,  1'b0, 1'b0, 4'd10, 16'h0000, 1'b0, 1'b1};
        tbl[5]  = '{12'h800, 5'd30, 1'b1, 1'b1, 4'd0,  16'hFC00, 1'b1, 1'b0};
        tbl[6]  = '{12'h000, 5'd15, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{12'h001, 5'd20, 1'b0, 1'b0, 4'd15, 16'h2800, 1'b0, 1'b0};
        tbl[8]  = '{12'h400, 5'd31, 1'b0, 1'b0, 4'd0,  16'h7C00, 1'b1, 1'b0};
        tbl[9]  = '{12'h400, 5'd1,  1'b1, 1'b0, 4'd0,  16'h8400, 1'b0, 1'b0};
        tbl[10] = '{12'h400, 5'd0,  1'b1, 1'b0, 4'd0,  16'h8000, 1'b0, 1'b1};
        tbl[11] = '{12'h801, 5'd15, 1'b0, 1'b1, 4'd0,  16'h4000, 1'b0, 1'b0};
        tbl[12] = '{12'h123, 5'd15, 1'b0, 1'b0, 4'd2,  16'h348C, 1'b0, 1'b0};
        tbl[13] = '{12'h000, 5'd31, 1'b0, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        set_in(12'h0, 5'd0, 1'b0, 1'b0, 4'd0);
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result",    32'(result),    32'd0);
        check("reset ovf",       32'(ovf),       32'd0);
        check("reset unf",       32'(unf),       32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: exact 2-cycle latency, value and flags.
        foreach (tbl[i]) begin
            clr_pulse();
            set_in(tbl[i].m, tbl[i].e, tbl[i].s, tbl[i].d, tbl[i].n);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d early valid", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d valid", i),  32'(out_valid), 32'd1);
            check($sformatf("vec%0d result", i), 32'(result),    32'(tbl[i].res));
            check($sformatf("vec%0d ovf", i),    32'(ovf),       32'(tbl[i].ovf));
            check($sformatf("vec%0d unf", i),    32'(unf),       32'(tbl[i].unf));
        end
        @(posedge clk); #1;

        // Sticky flags: clear, then clear colliding with a set.
        check("ovf before clear", 32'(ovf), 32'd0);
        drive(12'h800, 5'd30, 1'b1, 1'b1, 4'd0);
        @(posedge clk); #1;
        check("ovf set", 32'(ovf), 32'd1);
        clr_pulse();
        check("ovf cleared", 32'(ovf), 32'd0);
        set_in(12'h001, 5'd5, 1'b0, 1'b0, 4'd10);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("set beats clear", 32'(unf), 32'd1);
        clr_pulse();
        check("unf cleared", 32'(unf), 32'd0);
        @(posedge clk); #1;

        // Five-beat stream with a 3-cycle downstream stall.
        base = popped;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    drive(12'h400 + 12'(k * 3), 5'd10 + 5'(k), k[0], 1'b0, 4'd0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = result;
                check("stall in_ready", 32'(in_ready), 32'd0);
                repeat (2) begin
                    @(negedge clk);
                    check("stall in_ready", 32'(in_ready),  32'd0);
                    check("stall valid",    32'(out_valid), 32'd1);
                    check("stall stable",   32'(result),    32'(held));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("stall drain");
        check("stall count", 32'(popped - base), 32'd5);

        // Reset with two beats in flight.
        set_in(12'h400, 5'd15, 1'b0, 1'b0, 4'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_in(12'h600, 5'd16, 1'b1, 1'b0, 4'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid", 32'(out_valid), 32'd0);
        check("reset in_ready",    32'(in_ready),  32'd1);
        check("reset result 2",    32'(result),    32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no stale 1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("no stale 2", 32'(out_valid), 32'd0);
        set_in(12'h803, 5'd15, 1'b0, 1'b1, 4'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post-reset early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("post-reset valid",  32'(out_valid), 32'd1);
        check("post-reset result", 32'(result),    32'h4002);
        @(posedge clk); #1;

        // Randomized stream with random backpressure.
        clr_pulse();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    drive(($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(0, 4095)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("random drain");
        check("random ovf", 32'(ovf), 32'(mdl_ovf));
        check("random unf", 32'(unf), 32'(mdl_unf));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
